// File: rtl/coin_pkg.sv
// Shared types and widths for the coin pulse conditioner and its debouncer.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } coin_state_t;

  localparam int FCNT_W         = 8;
  localparam int DEB_CYCLES_DEF = 48000;
  localparam int DEB_CNT_W_DEF  = $clog2(DEB_CYCLES_DEF + 1);

  function automatic int deb_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus stable-time debouncer for one raw button,
// exposing the debounced level and a one-cycle rising-edge request.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn_db,
  output logic o_req
);

  localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_db;
  logic             r_btn_db_d;
  logic [CNT_W-1:0] r_deb_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_deb_cnt  <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_btn_db_d <= r_btn_db;
      // The counter only advances while the synchronised level disagrees.
      if (r_sync2 == r_btn_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == CNT_LAST) begin
        r_btn_db  <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign o_btn_db = r_btn_db;
  assign o_req    = r_btn_db & ~r_btn_db_d;

endmodule

// File: rtl/coin_pulser.sv
// Turns debounced coin presses into frame-aligned pulses of fixed frame
// length with a minimum frame gap, queueing presses up to QMAX.
module coin_pulser
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES   = 48000,
  parameter int PULSE_FRAMES = 4,
  parameter int GAP_FRAMES   = 4,
  parameter int QMAX         = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_in,
  input  logic                       vblank,
  input  logic                       pause,
  output logic                       coin_out,
  output logic                       busy,
  output logic [$clog2(QMAX+1)-1:0]  pending
);

  localparam int PW = $clog2(QMAX + 1);
  localparam logic [PW-1:0]     P_MAX   = PW'(QMAX);
  localparam logic [FCNT_W-1:0] F_PULSE = FCNT_W'(PULSE_FRAMES);
  localparam logic [FCNT_W-1:0] F_GAP   = FCNT_W'(GAP_FRAMES);

  logic              w_btn_db;
  logic              w_req;
  logic              w_unused_btn_db;
  logic              w_tick;
  logic              w_consume;
  coin_state_t       w_state_nx;
  logic [FCNT_W-1:0] w_fcnt_nx;
  logic              w_coin_nx;
  logic [PW-1:0]     w_pending_nx;

  coin_state_t       r_state;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_coin;
  logic              r_busy;
  logic [PW-1:0]     r_pending;
  logic              r_vb_q;

  coin_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_btn    (btn_in),
    .o_btn_db (w_btn_db),
    .o_req    (w_req)
  );

  assign w_unused_btn_db = w_btn_db;
  assign w_tick          = vblank & ~r_vb_q & ~pause;

  always_comb begin
    w_state_nx = r_state;
    w_fcnt_nx  = r_fcnt;
    w_coin_nx  = r_coin;
    w_consume  = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_pending != '0) && !pause) w_state_nx = ALIGN;
      end
      ALIGN: begin
        if (w_tick) begin
          w_state_nx = PULSE;
          w_coin_nx  = 1'b1;
          w_fcnt_nx  = FCNT_W'(1);
          w_consume  = 1'b1;
        end
      end
      PULSE: begin
        if (w_tick) begin
          if (r_fcnt == F_PULSE) begin
            w_state_nx = GAP;
            w_coin_nx  = 1'b0;
            w_fcnt_nx  = FCNT_W'(1);
          end else begin
            w_fcnt_nx = r_fcnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (w_tick) begin
          if (r_fcnt == F_GAP) w_state_nx = IDLE;
          else                 w_fcnt_nx  = r_fcnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_coin_nx  = 1'b0;
      end
    endcase
  end

  // A simultaneous request and consume cancel, even when the queue is full.
  always_comb begin
    w_pending_nx = r_pending;
    if (w_req && !w_consume) begin
      if (r_pending != P_MAX) w_pending_nx = r_pending + 1'b1;
    end else if (!w_req && w_consume) begin
      w_pending_nx = r_pending - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_fcnt    <= '0;
      r_coin    <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= '0;
      r_vb_q    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_fcnt    <= w_fcnt_nx;
      r_coin    <= w_coin_nx;
      r_busy    <= (w_state_nx != IDLE);
      r_pending <= w_pending_nx;
      r_vb_q    <= vblank;
    end
  end

  assign coin_out = r_coin;
  assign busy     = r_busy;
  assign pending  = r_pending;

endmodule

// File: tb/tb_coin_pulser.sv
// Randomised and scenario stimulus for coin_pulser, compared every cycle
// against a frame-level behavioural model of the coin rules.
module tb_coin_pulser;

  localparam int DEB = 4;
  localparam int PF  = 2;
  localparam int GF  = 2;
  localparam int QM  = 3;
  localparam int VBP = 100;
  localparam int VBH = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       vblank;
  logic       pause;
  logic       coin_out;
  logic       busy;
  logic [1:0] pending;

  coin_pulser #(
    .DEB_CYCLES   (DEB),
    .PULSE_FRAMES (PF),
    .GAP_FRAMES   (GF),
    .QMAX         (QM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .vblank   (vblank),
    .pause    (pause),
    .coin_out (coin_out),
    .busy     (busy),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 waiting for coins, 1 waiting for a frame,
  // 2 pulse high, 3 enforced low gap; frames remaining kept in m_left.
  int m_pend;
  bit m_req;
  bit m_db;
  bit hist[8];
  bit m_vbq;
  int m_ph;
  int m_left;
  bit m_coin;

  int vb_cnt = 0;
  int n_rise;
  int high_cnt;
  int max_pend;
  bit prev_coin = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_req = 0; m_db = 0; m_vbq = 0;
    m_ph = 0; m_left = 0; m_coin = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
  endtask

  task automatic model_step();
    bit tick, consume, flip;
    int old_pend;
    tick     = vblank && !m_vbq && !pause;
    old_pend = m_pend;
    consume  = (m_ph == 1) && tick;
    if (m_req && !consume) begin
      if (m_pend < QM) m_pend++;
    end else if (!m_req && consume) begin
      m_pend--;
    end
    case (m_ph)
      0: if (old_pend != 0 && !pause) m_ph = 1;
      1: if (tick) begin m_ph = 2; m_coin = 1; m_left = PF; end
      2: if (tick) begin
           m_left--;
           if (m_left == 0) begin m_ph = 3; m_coin = 0; m_left = GF; end
         end
      default: if (tick) begin
           m_left--;
           if (m_left == 0) m_ph = 0;
         end
    endcase
    // Level accepted once the last DEB synchronised samples all disagree.
    flip = 1;
    for (int i = 1; i <= DEB; i++) if (hist[i] == m_db) flip = 0;
    m_req = flip && !m_db;
    if (flip) m_db = !m_db;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btn_in;
    m_vbq = vblank;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("coin_out", coin_out, m_coin);
    check_eq("busy", busy, (m_ph != 0));
    check_eq("pending", pending, m_pend);
    if (coin_out === 1'b1 && prev_coin == 1'b0) n_rise++;
    if (coin_out === 1'b1) high_cnt++;
    if (int'(pending) > max_pend) max_pend = int'(pending);
    prev_coin = coin_out;
    vb_cnt = (vb_cnt + 1) % VBP;
    vblank = (vb_cnt < VBH);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int hi, input int lo);
    btn_in = 1'b1; run(hi);
    btn_in = 1'b0; run(lo);
  endtask

  task automatic clear_meas();
    n_rise = 0; high_cnt = 0; max_pend = 0;
  endtask

  task automatic sync_frame();
    for (int i = 0; i < 2 * VBP && vb_cnt != VBH + 1; i++) step();
  endtask

  task automatic wait_coin();
    for (int i = 0; i < 400 && coin_out !== 1'b1; i++) step();
    check_eq("wait_coin", coin_out, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (busy !== 1'b0 || pending !== 2'd0); i++) step();
    check_eq("drain_busy", busy, 0);
    check_eq("drain_pending", pending, 0);
  endtask

  initial begin
    int lat;
    reset = 1'b1; btn_in = 1'b0; pause = 1'b0; vblank = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_coin", coin_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pending", pending, 0);
    reset = 1'b0;
    run(5);

    // Single press: request latency and one pulse of two frames.
    clear_meas();
    btn_in = 1'b1;
    lat = 0;
    while (lat < 20 && pending !== 2'd1) begin step(); lat++; end
    check_eq("press_latency", lat, 7);
    run(20 - lat);
    btn_in = 1'b0;
    run(700);
    check_eq("single_rises", n_rise, 1);
    check_eq("single_high", high_cnt, PF * VBP);

    // Bounce shorter than the debounce time is ignored.
    clear_meas();
    repeat (5) press(3, 17);
    run(200);
    check_eq("bounce_rises", n_rise, 0);
    check_eq("bounce_maxpend", max_pend, 0);

    // Burst of three presses within one frame.
    drain();
    sync_frame();
    clear_meas();
    repeat (3) press(8, 12);
    run(1700);
    check_eq("burst_maxpend", max_pend, 3);
    check_eq("burst_rises", n_rise, 3);
    check_eq("burst_high", high_cnt, 3 * PF * VBP);

    // Saturation: five presses during the first pulse.
    drain();
    sync_frame();
    clear_meas();
    press(8, 12);
    wait_coin();
    repeat (5) press(8, 12);
    run(2500);
    check_eq("sat_maxpend", max_pend, QM);
    check_eq("sat_rises", n_rise, 4);

    // Pause across five frame boundaries in the middle of a pulse.
    drain();
    sync_frame();
    clear_meas();
    press(8, 12);
    wait_coin();
    run(50);
    pause = 1'b1; run(500);
    pause = 1'b0; run(800);
    check_eq("pause_rises", n_rise, 1);
    check_eq("pause_high", high_cnt, 700);

    // Random presses, bounce and pause windows.
    drain();
    for (int k = 0; k < 250; k++) begin
      btn_in = 1'($urandom % 2);
      if ($urandom % 8 == 0) pause = ~pause;
      run($urandom_range(1, 30));
    end
    pause = 1'b0; btn_in = 1'b0;

    // Asynchronous reset mid-pulse with two coins still queued.
    drain();
    sync_frame();
    repeat (3) press(8, 12);
    wait_coin();
    check_eq("prereset_pending", pending, 2);
    #2 reset = 1'b1;
    #1;
    check_eq("areset_coin", coin_out, 0);
    check_eq("areset_busy", busy, 0);
    check_eq("areset_pending", pending, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    prev_coin = 1'b0;
    clear_meas();
    run(800);
    check_eq("post_reset_rises", n_rise, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
